// File: rtl/port_pkg.sv
// Shared definitions for the CPU byte ports (oport / iport) and the opcode
// the CPU FSM decodes to strobe the input port.
package port_pkg;
   localparam int PORT_W      = 8;
   localparam int IPORT_DEPTH = 4;

   localparam logic [3:0] OP_IN = 4'hD;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

   function automatic occ_e occ_state(input int cnt, input int depth);
      if (cnt == 0)          return OCC_EMPTY;
      else if (cnt == depth) return OCC_FULL;
      else                   return OCC_PARTIAL;
   endfunction
endpackage

// File: rtl/port_fifo.sv
// Generic synchronous FIFO; occupancy count is the single source of truth
// for full/empty so the pointers can wrap freely.
module port_fifo
   import port_pkg::*;
#(
   parameter int DEPTH = IPORT_DEPTH,
   parameter int WIDTH = PORT_W,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   // full refuses a write even if a read frees a slot on the same edge
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/iport_controller.sv
// CPU input port: producer valid/ready into a small FIFO, CPU reads the head
// and pops with rd_en; reading while empty latches a sticky debug flag.
module iport_controller
   import port_pkg::*;
#(
   parameter int DEPTH = IPORT_DEPTH,
   parameter int WIDTH = PORT_W,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             rd_en,
   output logic [WIDTH-1:0] iport,
   output logic             iport_valid,
   output logic [CW-1:0]    count,
   output logic             underflow,
   input  logic             clear_err
);
   logic [WIDTH-1:0] head;
   logic             full, empty;

   port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (in_valid),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign in_ready    = !full;
   assign iport_valid = !empty;
   // storage is never cleared, so mask stale bytes while empty
   assign iport       = iport_valid ? head : '0;

   always_ff @(posedge clk) begin
      if (reset)                    underflow <= 1'b0;
      else if (rd_en && empty)      underflow <= 1'b1;
      else if (clear_err)           underflow <= 1'b0;
   end
endmodule

// File: tb/tb_iport_controller.sv
// Directed bench for iport_controller: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_iport_controller;
   localparam int DEPTH = 4;
   localparam int WIDTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             rd_en;
   logic [WIDTH-1:0] iport;
   logic             iport_valid;
   logic [CW-1:0]    count;
   logic             underflow;
   logic             clear_err;

   int n_chk  = 0;
   int n_fail = 0;

   iport_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .rd_en       (rd_en),
      .iport       (iport),
      .iport_valid (iport_valid),
      .count       (count),
      .underflow   (underflow),
      .clear_err   (clear_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: FIFO as a queue, rules applied at each rising edge
   logic [WIDTH-1:0] q[$];
   bit               m_uf   = 1'b0;
   bit               chk_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_uf   = 1'b0;
         chk_en = 1'b1;
      end else begin
         bit do_push, do_pop;
         do_push = in_valid && (q.size() < DEPTH);
         do_pop  = rd_en && (q.size() > 0);
         if (rd_en && q.size() == 0) m_uf = 1'b1;
         else if (clear_err)         m_uf = 1'b0;
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_in_ready",    32'(in_ready),    32'(q.size() != DEPTH));
         check("model_iport_valid", 32'(iport_valid), 32'(q.size() != 0));
         check("model_iport",       32'(iport),       (q.size() != 0) ? 32'(q[0]) : 32'h0);
         check("model_count",       32'(count),       32'(q.size()));
         check("model_underflow",   32'(underflow),   32'(m_uf));
      end
   end

   // apply inputs for one edge, return #1 after it
   task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
      in_valid  = v;
      in_data   = d;
      rd_en     = r;
      clear_err = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; rd_en = 1'b0; clear_err = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: reset state, then reset with data buffered
      cyc(0, 8'h00, 0, 0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_valid",    32'(iport_valid), 32'd0);
      check("rst_iport",    32'(iport), 32'h00);
      check("rst_count",    32'(count), 32'd0);
      check("rst_uf",       32'(underflow), 32'd0);
      cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0);
      check("pre_rst_count", 32'(count), 32'd3);
      reset = 1'b1;
      cyc(1, 8'h44, 1, 0);
      reset = 1'b0;
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_iport", 32'(iport), 32'h00);

      // 2: push three, pop three
      cyc(1, 8'hA5, 0, 0); cyc(1, 8'h3C, 0, 0); cyc(1, 8'h7E, 0, 0);
      check("t2_count", 32'(count), 32'd3);
      check("t2_head",  32'(iport), 32'hA5);
      cyc(0, 8'h00, 1, 0); check("t2_pop1", 32'(iport), 32'h3C);
      cyc(0, 8'h00, 1, 0); check("t2_pop2", 32'(iport), 32'h7E);
      cyc(0, 8'h00, 1, 0); check("t2_pop3", 32'(iport), 32'h00);
      check("t2_valid", 32'(iport_valid), 32'd0);

      // 3: full, then push+pop while full refuses the push
      for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0);
      check("t3_full_ready", 32'(in_ready), 32'd0);
      check("t3_full_count", 32'(count), 32'd4);
      cyc(1, 8'h05, 1, 0);
      check("t3_count", 32'(count), 32'd3);
      check("t3_ready", 32'(in_ready), 32'd1);
      check("t3_head",  32'(iport), 32'h02);
      cyc(1, 8'h05, 0, 0);
      check("t3_retry_count", 32'(count), 32'd4);
      for (int i = 2; i <= 5; i++) begin
         check("t3_drain", 32'(iport), 32'(i));
         cyc(0, 8'h00, 1, 0);
      end
      check("t3_empty", 32'(count), 32'd0);

      // 4: steady push+pop at count=2 across pointer wraps
      cyc(1, 8'hE0, 0, 0); cyc(1, 8'hE1, 0, 0);
      for (int k = 0; k < 10; k++) begin
         cyc(1, 8'h10 + 8'(k), 1, 0);
         check("t4_count", 32'(count), 32'd2);
         check("t4_head",  32'(iport), (k == 0) ? 32'hE1 : 32'h10 + 32'(k) - 32'd1);
      end
      cyc(0, 8'h00, 1, 0); check("t4_tail1", 32'(iport), 32'h19);
      cyc(0, 8'h00, 1, 0); check("t4_tail2", 32'(count), 32'd0);

      // 5: underflow behaviour
      cyc(1, 8'h99, 1, 0);
      check("t5_uf",    32'(underflow), 32'd1);
      check("t5_count", 32'(count), 32'd1);
      check("t5_iport", 32'(iport), 32'h99);
      cyc(0, 8'h00, 1, 0);
      check("t5_popped", 32'(count), 32'd0);
      cyc(0, 8'h00, 1, 1);
      check("t5_set_wins", 32'(underflow), 32'd1);
      cyc(0, 8'h00, 0, 1);
      check("t5_clear", 32'(underflow), 32'd0);
      cyc(0, 8'h55, 0, 0);
      check("t5_ignore_data", 32'(count), 32'd0);
      check("t5_iport_zero",  32'(iport), 32'h00);

      cyc(0, 8'h00, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
